// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port shared by an ALU (A) and a load (B) path,
// with a destination busy scoreboard and a source read-hazard stall toward issue.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic                      a_valid,
  input  logic [ADDR_W-1:0]         a_addr,
  input  logic [DATA_W-1:0]         a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [ADDR_W-1:0]         b_addr,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      b_ready,
  output logic                      rf_write_ena,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_data,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [ADDR_W-1:0]         rd2_addr,
  output logic                      stall,
  output logic [(1<<ADDR_W)-1:0]    busy
);

  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e            last_q, last_d;
  logic              grant_a, grant_b;
  logic              acc, w_real;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   busy_q, busy_d;

  // Arbitration: lone requester wins; on conflict either fixed A or alternate
  always_comb begin
    last_d  = last_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if ((FIXED_PRIO != 0) || (last_q == GRANT_B)) grant_a = 1'b1;
      else                                          grant_b = 1'b1;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
    if (grant_a)      last_d = GRANT_A;
    else if (grant_b) last_d = GRANT_B;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign acc    = grant_a | grant_b;
  assign w_addr = grant_a ? a_addr : b_addr;
  assign w_data = grant_a ? a_data : b_data;
  // x0 writes are accepted but never reach the register file
  assign w_real = acc && (w_addr != '0);

  // Scoreboard update: clear on accept, then set on reserve so a same-edge reserve wins
  always_comb begin
    busy_d = busy_q;
    if (w_real) busy_d[w_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q        <= GRANT_B;
      busy_q        <= '0;
      rf_write_ena  <= 1'b0;
      rf_write_addr <= '0;
      rf_data       <= '0;
    end else begin
      last_q       <= last_d;
      busy_q       <= busy_d;
      rf_write_ena <= w_real;
      if (w_real) begin
        rf_write_addr <= w_addr;
        rf_data       <= w_data;
      end
    end
  end

  // A source is hazardous while reserved or while its write sits between accept and commit
  function automatic logic hazard(input logic [ADDR_W-1:0] r);
    return (r != '0) && (busy_q[r] || (rf_write_ena && (rf_write_addr == r)));
  endfunction

  assign stall = hazard(rd1_addr) | hazard(rd2_addr);
  assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the writeback port and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rsv_valid = 1'b0;
  logic [ADDR_W-1:0] rsv_addr = '0;
  logic              a_valid = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_data = '0;
  logic              b_valid = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic [ADDR_W-1:0] rd1_addr = '0;
  logic [ADDR_W-1:0] rd2_addr = '0;

  logic              a_ready, b_ready, rf_write_ena, stall;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_data;
  logic [NREG-1:0]   busy;

  logic              f_a_ready, f_b_ready, f_rf_write_ena, f_stall;
  logic [ADDR_W-1:0] f_rf_write_addr;
  logic [DATA_W-1:0] f_rf_data;
  logic [NREG-1:0]   f_busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_write_ena(rf_write_ena), .rf_write_addr(rf_write_addr), .rf_data(rf_data),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .stall(stall), .busy(busy)
  );

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(f_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(f_b_ready),
    .rf_write_ena(f_rf_write_ena), .rf_write_addr(f_rf_write_addr), .rf_data(f_rf_data),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .stall(f_stall), .busy(f_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state for the round-robin instance
  logic [NREG-1:0]   m_busy;
  logic              m_ena;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_prefer_a;
  logic              acc_a, acc_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {grant A, grant B} for the current inputs
  function automatic logic [1:0] exp_grant();
    if (a_valid && b_valid) return m_prefer_a ? 2'b10 : 2'b01;
    return {a_valid, b_valid};
  endfunction

  function automatic logic exp_hazard(input logic [ADDR_W-1:0] r);
    if (r == 0) return 1'b0;
    return m_busy[r] || (m_ena && m_addr == r);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [1:0]        g;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    if (!rst) begin
      m_busy = '0; m_ena = 1'b0; m_addr = '0; m_data = '0;
      m_prefer_a = 1'b1; acc_a = 1'b0; acc_b = 1'b0;
    end else begin
      g = exp_grant();
      acc_a = g[1];
      acc_b = g[0];
      wa = acc_a ? a_addr : b_addr;
      wd = acc_a ? a_data : b_data;
      m_ena = (acc_a || acc_b) && (wa != 0);
      if (m_ena) begin
        m_busy[wa] = 1'b0;
        m_addr = wa;
        m_data = wd;
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (acc_a || acc_b) m_prefer_a = acc_b;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic [1:0] g;
    g = exp_grant();
    chk("a_ready", 64'(a_ready), 64'(g[1]));
    chk("b_ready", 64'(b_ready), 64'(g[0]));
    chk("stall", 64'(stall), 64'(exp_hazard(rd1_addr) | exp_hazard(rd2_addr)));
    chk("rf_write_ena", 64'(rf_write_ena), 64'(m_ena));
    if (m_ena) begin
      chk("rf_write_addr", 64'(rf_write_addr), 64'(m_addr));
      chk("rf_data", 64'(rf_data), 64'(m_data));
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("fixed_a_ready", 64'(f_a_ready), 64'(a_valid));
    chk("fixed_b_ready", 64'(f_b_ready), 64'(b_valid && !a_valid));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int unsigned ca, cb;
    logic exp_a;

    // Reset with A already requesting
    #1 rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11; rd1_addr = 5'd3;
    #11;
    chk("reset_ena", 64'(rf_write_ena), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_stall", 64'(stall), 64'h0);
    tick();
    rst = 1'b1;
    #1 chk("post_reset_a_ready", 64'(a_ready), 64'h1);
    tick();
    a_valid = 1'b0;
    chk("post_reset_ena", 64'(rf_write_ena), 64'h1);
    chk("post_reset_addr", 64'(rf_write_addr), 64'h3);
    chk("post_reset_data", 64'(rf_data), 64'h11);

    // Single reserved write to x5
    tick();
    rsv_valid = 1'b1; rsv_addr = 5'd5; rd1_addr = 5'd5;
    tick();
    rsv_valid = 1'b0;
    chk("sw_busy5", 64'(busy[5]), 64'h1);
    chk("sw_stall_rsv", 64'(stall), 64'h1);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1 chk("sw_a_ready", 64'(a_ready), 64'h1);
    tick();
    a_valid = 1'b0;
    chk("sw_ena", 64'(rf_write_ena), 64'h1);
    chk("sw_addr", 64'(rf_write_addr), 64'h5);
    chk("sw_data", 64'(rf_data), 64'hDEADBEEF);
    chk("sw_busy5_clr", 64'(busy[5]), 64'h0);
    chk("sw_stall_inflight", 64'(stall), 64'h1);
    tick();
    chk("sw_stall_done", 64'(stall), 64'h0);
    chk("sw_ena_done", 64'(rf_write_ena), 64'h0);

    // Lone B write so the next conflict goes to A
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    #1 chk("b_single_ready", 64'(b_ready), 64'h1);
    tick();
    b_valid = 1'b0;

    // Four conflicting cycles: A, B, A, B; fixed instance always A
    ca = 10; cb = 20;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = ADDR_W'(ca); b_addr = ADDR_W'(cb);
    a_data = 32'hA000_0000; b_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2) == 0;
      #1;
      chk("rr_a_ready", 64'(a_ready), 64'(exp_a));
      chk("rr_b_ready", 64'(b_ready), 64'(!exp_a));
      chk("fix_a_ready", 64'(f_a_ready), 64'h1);
      chk("fix_b_ready", 64'(f_b_ready), 64'h0);
      tick();
      chk("rr_wr_addr", 64'(rf_write_addr), exp_a ? 64'(ca) : 64'(cb));
      if (exp_a) begin ca++; a_addr = ADDR_W'(ca); a_data = a_data + 32'h1; end
      else       begin cb++; b_addr = ADDR_W'(cb); b_data = b_data + 32'h1; end
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // x0: reservation ignored, write accepted but not performed
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
    rd1_addr = 5'd0; rd2_addr = 5'd0;
    #1;
    chk("x0_b_ready", 64'(b_ready), 64'h1);
    chk("x0_stall", 64'(stall), 64'h0);
    tick();
    rsv_valid = 1'b0; b_valid = 1'b0;
    chk("x0_busy", 64'(busy), 64'h0);
    chk("x0_ena", 64'(rf_write_ena), 64'h0);
    chk("x0_stall_after", 64'(stall), 64'h0);

    // Same-edge reserve and write to x7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77; rd1_addr = 5'd7;
    #1 chk("sc_a_ready", 64'(a_ready), 64'h1);
    tick();
    rsv_valid = 1'b0; a_valid = 1'b0;
    chk("sc_busy7", 64'(busy[7]), 64'h1);
    chk("sc_ena", 64'(rf_write_ena), 64'h1);
    chk("sc_addr", 64'(rf_write_addr), 64'h7);
    chk("sc_data", 64'(rf_data), 64'h77);
    chk("sc_stall", 64'(stall), 64'h1);

    // Asynchronous reset one cycle after an accept
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    #1 chk("ar_a_ready", 64'(a_ready), 64'h1);
    tick();
    rsv_valid = 1'b0; a_valid = 1'b0;
    chk("ar_ena_before", 64'(rf_write_ena), 64'h1);
    chk("ar_addr_before", 64'(rf_write_addr), 64'h6);
    #2 rst = 1'b0;
    #1;
    chk("ar_ena_dropped", 64'(rf_write_ena), 64'h0);
    chk("ar_busy_cleared", 64'(busy), 64'h0);
    chk("ar_stall", 64'(stall), 64'h0);
    a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
    tick();
    chk("ar_ena_in_reset", 64'(rf_write_ena), 64'h0);
    rst = 1'b1;
    #1 chk("ar_rearb_ready", 64'(a_ready), 64'h1);
    tick();
    a_valid = 1'b0;
    chk("ar_rearb_ena", 64'(rf_write_ena), 64'h1);
    chk("ar_rearb_addr", 64'(rf_write_addr), 64'h8);
    chk("ar_rearb_data", 64'(rf_data), 64'h88);

    // Random traffic; requesters hold until the model says they were accepted
    for (int n = 0; n < 500; n++) begin
      tick();
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ADDR_W'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = ADDR_W'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = ADDR_W'($urandom_range(0, 7));
      rd1_addr  = ADDR_W'($urandom_range(0, 7));
      rd2_addr  = ADDR_W'($urandom_range(0, 7));
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU path) and B (load/memory path).
- Tracks outstanding destination reservations in a 32-entry busy scoreboard.
- Raises a read-hazard stall toward issue logic.
- Sits between the execute/memory stages and the register file; drives the register file's write enable, write address and write data.

Parameters:
- ADDR_W, 5, register address width (2^ADDR_W registers).
- DATA_W, 32, register data width.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- rsv_valid  input  1  reserve a destination register at issue.
- rsv_addr  input  ADDR_W  register being reserved.
- a_valid  input  1  requester A has a write.
- a_addr  input  ADDR_W  requester A destination.
- a_data  input  DATA_W  requester A data.
- a_ready  output  1  requester A accepted this cycle (combinational).
- b_valid  input  1  requester B has a write.
- b_addr  input  ADDR_W  requester B destination.
- b_data  input  DATA_W  requester B data.
- b_ready  output  1  requester B accepted this cycle (combinational).
- rf_write_ena  output  1  register-file write enable (registered).
- rf_write_addr  output  ADDR_W  register-file write address (registered).
- rf_data  output  DATA_W  register-file write data (registered).
- rd1_addr  input  ADDR_W  issue-stage source 1.
- rd2_addr  input  ADDR_W  issue-stage source 2.
- stall  output  1  source hazard (combinational).
- busy  output  2^ADDR_W  scoreboard bits.

Behaviour:
- Reset (rst=0, asynchronous): rf_write_ena=0, rf_write_addr=0, rf_data=0, busy=0, last_grant=B (so A wins the first conflict).
- Handshake: a transfer occurs in any cycle where valid and ready are both high. The requester holds addr/data stable until accepted. Ready never waits on the same requester's valid deasserting.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid, FIXED_PRIO=0: grant the requester not granted last; last_grant updates only on a conflict or a single grant.
  - Both valid, FIXED_PRIO=1: A always wins.
  - Loser holds its request, ready=0.
- Write latency: accept at edge N drives rf_write_ena/addr/data during cycle N+1. The register file commits at edge N+1. With no accept, rf_write_ena=0 next cycle; addr/data hold their last values.
- x0: writes to address 0 are accepted (ready=1) but produce rf_write_ena=0. Reservations of address 0 are ignored. busy[0] is always 0.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the clock edge.
  - An accepted write to address r clears busy[r] at the accept edge.
  - Same-edge reserve and accept to the same r: set wins (busy[r] stays 1).
  - Reserving an already-busy register leaves it 1 (no counting; issue logic must not reserve a busy register).
  - A write to a non-busy register is legal; it is performed and busy is unchanged.
- Stall:
  - stall = hazard(rd1_addr) | hazard(rd2_addr).
  - hazard(r) = (r≠0) & (busy[r] | (rf_write_ena & rf_write_addr==r)).
  - The second term covers the cycle between accept and commit. No forwarding.
- Reset mid-operation: all pending state is lost. A requester holding valid is re-arbitrated after rst deasserts. Nothing is written on the reset cycle.

Test Plan:
- Reset: rst=0 with a_valid=1 → rf_write_ena=0, busy=0, stall=0. After release, A is accepted next cycle; rf_write_ena=1 one cycle after accept.
- Single write: rsv x5, then a_valid with a_addr=5, a_data=0xDEADBEEF:
  - busy[5]=1 and stall=1 for rd1_addr=5 until the accept edge.
  - Next cycle: rf_write_ena=1, rf_write_addr=5, rf_data=0xDEADBEEF, stall still 1.
  - Following cycle: stall=0.
- Conflict round-robin: A and B both valid for 4 cycles with distinct addresses → grants A, B, A, B. With FIXED_PRIO=1 → A every cycle, b_ready=0.
- x0 handling: rsv x0 and b_valid with b_addr=0, b_data=0x1234 → b_ready=1, busy[0]=0, rf_write_ena=0, stall=0 for rd2_addr=0.
- Simultaneous set/clear: accept write to x7 on the same edge as rsv x7 → busy[7]=1 afterwards and rf_write_ena=1 with addr 7 next cycle.
- Async reset mid-write: assert rst low between clock edges one cycle after accept → rf_write_ena drops to 0 immediately (before the next edge) and busy clears.
